// File: rtl/ahb_rif_arbiter.sv
// Round-robin arbiter multiplexing NUM_REQ requesters onto a single RIF port,
// with registered responses and optional bounded exclusive (locked) sequences.
module ahb_rif_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_COUNT = DATA_WIDTH/8,
  parameter int MAX_LOCK   = 4
) (
  input  logic                             HCLK,
  input  logic                             HRESETn,
  input  logic [NUM_REQ-1:0]               i_req_valid,
  input  logic [NUM_REQ-1:0]               i_req_write,
  input  logic [NUM_REQ-1:0]               i_req_lock,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    i_req_addr,
  input  logic [NUM_REQ*BYTE_COUNT-1:0]    i_req_wstrb,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    i_req_wdata,
  output logic [NUM_REQ-1:0]               o_req_ready,
  output logic [NUM_REQ-1:0]               o_rsp_valid,
  output logic [DATA_WIDTH-1:0]            o_rsp_rdata,
  output logic                             o_rsp_err,
  output logic [ADDR_WIDTH-1:0]            o_rif_addr,
  input  logic                             i_rif_addr_valid,
  output logic                             o_rif_wr_req,
  output logic                             o_rif_rd_req,
  output logic [BYTE_COUNT-1:0]            o_rif_wstrb,
  output logic [DATA_WIDTH-1:0]            o_rif_wdata,
  input  logic [DATA_WIDTH-1:0]            i_rif_rdata
);

  localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W   = $clog2(MAX_LOCK + 1);
  localparam bit LOCK_EN = (MAX_LOCK > 1);

  typedef enum logic {
    ST_ARB    = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t                r_state;
  logic [PTR_W-1:0]      r_ptr;
  logic [PTR_W-1:0]      r_owner;
  logic [CNT_W-1:0]      r_lock_cnt;
  logic [NUM_REQ-1:0]    r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic                  r_rsp_err;

  logic                  w_gnt_any;
  logic [PTR_W-1:0]      w_gnt_idx;
  logic                  w_sel_write;
  logic                  w_sel_lock;
  logic                  w_lock_done;

  function automatic logic [PTR_W-1:0] f_next(input logic [PTR_W-1:0] idx);
    if (int'(idx) + 1 >= NUM_REQ) return '0;
    return idx + 1'b1;
  endfunction

  // Descending scan so the last hit is the first valid index at or after r_ptr.
  always_comb begin
    int c;
    c         = 0;
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    if (r_state == ST_LOCKED) begin
      if (i_req_valid[r_owner]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = r_owner;
      end
    end else begin
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        c = int'(r_ptr) + k;
        if (c >= NUM_REQ) c = c - NUM_REQ;
        if (i_req_valid[c]) begin
          w_gnt_any = 1'b1;
          w_gnt_idx = PTR_W'(c);
        end
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
      assign o_req_ready[gi] = w_gnt_any && (w_gnt_idx == PTR_W'(gi));
    end
  endgenerate

  assign w_sel_write  = i_req_write[w_gnt_idx];
  assign w_sel_lock   = i_req_lock[w_gnt_idx];
  assign w_lock_done  = !w_sel_lock || (int'(r_lock_cnt) + 1 == MAX_LOCK);

  assign o_rif_wr_req = w_gnt_any &&  w_sel_write;
  assign o_rif_rd_req = w_gnt_any && !w_sel_write;
  assign o_rif_addr   = w_gnt_any ? i_req_addr[w_gnt_idx*ADDR_WIDTH +: ADDR_WIDTH] : '0;
  assign o_rif_wstrb  = w_gnt_any ? i_req_wstrb[w_gnt_idx*BYTE_COUNT +: BYTE_COUNT] : '0;
  assign o_rif_wdata  = w_gnt_any ? i_req_wdata[w_gnt_idx*DATA_WIDTH +: DATA_WIDTH] : '0;

  assign o_rsp_valid  = r_rsp_valid;
  assign o_rsp_rdata  = r_rsp_rdata;
  assign o_rsp_err    = r_rsp_err;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state     <= ST_ARB;
      r_ptr       <= '0;
      r_owner     <= '0;
      r_lock_cnt  <= '0;
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= o_req_ready;
      if (w_gnt_any) begin
        r_rsp_rdata <= w_sel_write ? '0 : i_rif_rdata;
        r_rsp_err   <= !i_rif_addr_valid;
      end
      case (r_state)
        ST_ARB: begin
          if (w_gnt_any) begin
            if (LOCK_EN && w_sel_lock) begin
              r_state    <= ST_LOCKED;
              r_owner    <= w_gnt_idx;
              r_lock_cnt <= CNT_W'(1);
            end else begin
              r_ptr <= f_next(w_gnt_idx);
            end
          end
        end
        ST_LOCKED: begin
          // Owner dropping valid ends the lock with an idle cycle.
          if (w_gnt_any && !w_lock_done) begin
            r_lock_cnt <= r_lock_cnt + 1'b1;
          end else begin
            r_state    <= ST_ARB;
            r_ptr      <= f_next(r_owner);
            r_lock_cnt <= '0;
          end
        end
        default: r_state <= ST_ARB;
      endcase
    end
  end

endmodule
